// File: rtl/coloring_pkg.sv
// Shared color / history definitions for the color stream arbiter and the downstream checker.
package coloring_pkg;

   typedef logic [1:0] color_t;

   localparam color_t RED   = 2'b00;
   localparam color_t GREEN = 2'b01;
   localparam color_t BLUE  = 2'b10;
   localparam color_t SEP   = 2'b11;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      RUN1  = 2'd1,
      RUN2  = 2'd2
   } hist_state_t;

   // History state after emitting color x; last_color always becomes x.
   function automatic hist_state_t next_hist(hist_state_t s, color_t last, color_t x);
      return (s == RUN1 && x == last) ? RUN2 : RUN1;
   endfunction

endpackage

// File: rtl/color_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          hit
);

   always_comb begin
      int k;
      logic [IW-1:0] k_idx;
      onehot = '0;
      idx    = '0;
      hit    = 1'b0;
      k      = 0;
      k_idx  = '0;
      // Walk offsets from farthest to nearest so the closest hit to ptr wins.
      for (int j = N - 1; j >= 0; j--) begin
         k     = (int'(ptr) + j) % N;
         k_idx = IW'(k);
         if (elig[k_idx]) begin
            onehot        = '0;
            onehot[k_idx] = 1'b1;
            idx           = k_idx;
            hit           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/color_stream_arbiter.sv
// Round-robin arbiter merging N color requesters into one stream with no three equal colors in a row.
module color_stream_arbiter
   import coloring_pkg::*;
#(
   parameter int N         = 4,
   parameter int STALL_MAX = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [2*N-1:0] req_color,
   input  logic           flush,
   output logic [N-1:0]   grant,
   output logic           out_valid,
   output logic [1:0]     out_color,
   output logic           sep_pulse,
   output logic           err_illegal
);

   localparam int IW = $clog2(N);

   hist_state_t   state_q, state_d;
   color_t        last_color_q, last_color_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]    stall_q, stall_d;
   logic          out_valid_q, out_valid_d;
   color_t        out_color_q, out_color_d;
   logic          sep_pulse_q, sep_pulse_d;
   logic          err_illegal_q, err_illegal_d;

   logic [N-1:0]  elig, illegal, pick_onehot;
   logic [IW-1:0] pick_idx;
   logic          pick_hit, sep_due;
   color_t        gcolor;

   for (genvar gi = 0; gi < N; gi++) begin : g_elig
      assign illegal[gi] = req[gi] && (req_color[2*gi +: 2] == SEP);
      assign elig[gi]    = req[gi] && (req_color[2*gi +: 2] != SEP) &&
                           !(state_q == RUN2 && req_color[2*gi +: 2] == last_color_q);
   end

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .elig   (elig),
      .ptr    (rr_ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .hit    (pick_hit)
   );

   assign sep_due = (stall_q == 4'(STALL_MAX));
   assign grant   = (flush || sep_due) ? '0 : pick_onehot;

   always_comb begin
      gcolor = RED;
      for (int i = 0; i < N; i++) begin
         if (pick_onehot[i]) gcolor = req_color[2*i +: 2];
      end
   end

   always_comb begin
      state_d       = state_q;
      last_color_d  = last_color_q;
      rr_ptr_d      = rr_ptr_q;
      stall_d       = stall_q;
      out_valid_d   = 1'b0;
      out_color_d   = out_color_q;
      sep_pulse_d   = 1'b0;
      err_illegal_d = err_illegal_q | (|illegal);

      if (flush) begin
         state_d = EMPTY;
         stall_d = '0;
      end else if (sep_due) begin
         // Separator restarts the run history here and in the checker.
         out_valid_d = 1'b1;
         out_color_d = SEP;
         sep_pulse_d = 1'b1;
         state_d     = EMPTY;
         stall_d     = '0;
      end else if (pick_hit) begin
         out_valid_d  = 1'b1;
         out_color_d  = gcolor;
         state_d      = next_hist(state_q, last_color_q, gcolor);
         last_color_d = gcolor;
         rr_ptr_d     = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
         stall_d      = '0;
      end else if (req == '0) begin
         stall_d = '0;
      end else begin
         stall_d = stall_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= EMPTY;
         last_color_q  <= RED;
         rr_ptr_q      <= '0;
         stall_q       <= '0;
         out_valid_q   <= 1'b0;
         out_color_q   <= RED;
         sep_pulse_q   <= 1'b0;
         err_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_color_q  <= last_color_d;
         rr_ptr_q      <= rr_ptr_d;
         stall_q       <= stall_d;
         out_valid_q   <= out_valid_d;
         out_color_q   <= out_color_d;
         sep_pulse_q   <= sep_pulse_d;
         err_illegal_q <= err_illegal_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_color   = out_color_q;
   assign sep_pulse   = sep_pulse_q;
   assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_color_stream_arbiter.sv
// Directed scoreboard bench for color_stream_arbiter (N=4, STALL_MAX=4).
module tb_color_stream_arbiter;
   import coloring_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [7:0] req_color = '0;
   logic       flush = 1'b0;
   logic [3:0] grant;
   logic       out_valid;
   logic [1:0] out_color;
   logic       sep_pulse;
   logic       err_illegal;

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_q[$];   // {sep, color}

   always #5 clk = ~clk;

   color_stream_arbiter #(.N(4), .STALL_MAX(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_color   (req_color),
      .flush       (flush),
      .grant       (grant),
      .out_valid   (out_valid),
      .out_color   (out_color),
      .sep_pulse   (sep_pulse),
      .err_illegal (err_illegal)
   );

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Monitor: every presented output must match the oldest expectation.
   initial begin
      logic [2:0] e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got color=%0d sep=%0b expected no output", out_color, sep_pulse);
            end else begin
               e = exp_q.pop_front();
               $display("out color=%0d sep=%0b (expected color=%0d sep=%0b)", out_color, sep_pulse, e[1:0], e[2]);
               chk("out_color", int'(out_color), int'(e[1:0]));
               chk("sep_pulse", int'(sep_pulse), int'(e[2]));
            end
         end
      end
   end

   // One cycle: drive at posedge+1, check grant at negedge, queue the expected output.
   task automatic step(input string nm, input logic [3:0] r, input logic [7:0] c, input logic f,
                       input logic [3:0] eg, input logic pv, input logic [1:0] pc);
      req = r;
      req_color = c;
      flush = f;
      @(negedge clk);
      chk({nm, "_grant"}, int'(grant), int'(eg));
      if (pv) exp_q.push_back({pc == SEP, pc});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      flush = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values; grant depends only on req while held in reset.
      req = 4'b0101;
      @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_color", int'(out_color), 0);
      chk("rst_sep_pulse", int'(sep_pulse), 0);
      chk("rst_err", int'(err_illegal), 0);
      chk("rst_grant", int'(grant), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      req = '0;

      // Lone RED requester: two grants, four blocked cycles, separator, then RED again.
      step("t1_g1", 4'b0001, 8'h00, 1'b0, 4'b0001, 1'b1, RED);
      step("t1_g2", 4'b0001, 8'h00, 1'b0, 4'b0001, 1'b1, RED);
      for (int i = 0; i < 4; i++) step("t1_blk", 4'b0001, 8'h00, 1'b0, 4'b0000, 1'b0, RED);
      step("t1_sep", 4'b0001, 8'h00, 1'b0, 4'b0000, 1'b1, SEP);
      step("t1_after", 4'b0001, 8'h00, 1'b0, 4'b0001, 1'b1, RED);
      do_reset();

      // G,B,R,G continuously: rotation 0,1,2,3,0.
      step("t2_r0", 4'b1111, 8'h49, 1'b0, 4'b0001, 1'b1, GREEN);
      step("t2_r1", 4'b1111, 8'h49, 1'b0, 4'b0010, 1'b1, BLUE);
      step("t2_r2", 4'b1111, 8'h49, 1'b0, 4'b0100, 1'b1, RED);
      step("t2_r3", 4'b1111, 8'h49, 1'b0, 4'b1000, 1'b1, GREEN);
      step("t2_r4", 4'b1111, 8'h49, 1'b0, 4'b0001, 1'b1, GREEN);
      do_reset();

      // Build RUN2(BLUE) with rr_ptr back at 0, then req0 BLUE blocked, req1 RED granted.
      step("t3_b1", 4'b1000, 8'h80, 1'b0, 4'b1000, 1'b1, BLUE);
      step("t3_b2", 4'b1000, 8'h80, 1'b0, 4'b1000, 1'b1, BLUE);
      step("t3_sel", 4'b0011, 8'h02, 1'b0, 4'b0010, 1'b1, RED);
      chk("t3_state", int'(dut.state_q), int'(RUN1));
      chk("t3_last", int'(dut.last_color_q), int'(RED));

      // Illegal color on req2, req3 GREEN wins; error flag is sticky.
      step("t4_ill", 4'b1100, 8'h70, 1'b0, 4'b1000, 1'b1, GREEN);
      chk("t4_err_set", int'(err_illegal), 1);
      step("t4_idle", 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, RED);
      step("t4_idle", 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, RED);
      chk("t4_err_hold", int'(err_illegal), 1);

      // Flush with an eligible request: no grant, no output, history cleared, rr_ptr kept.
      step("t5_flush", 4'b0001, 8'h00, 1'b1, 4'b0000, 1'b0, RED);
      chk("t5_valid", int'(out_valid), 0);
      chk("t5_state", int'(dut.state_q), int'(EMPTY));
      step("t5_after", 4'b0001, 8'h00, 1'b0, 4'b0001, 1'b1, RED);

      // Stall to count 3, then asynchronous reset mid-cycle.
      step("t6_g", 4'b0001, 8'h00, 1'b0, 4'b0001, 1'b1, RED);
      for (int i = 0; i < 3; i++) step("t6_blk", 4'b0001, 8'h00, 1'b0, 4'b0000, 1'b0, RED);
      chk("t6_stall", int'(dut.stall_q), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid", int'(out_valid), 0);
      chk("t6_sep", int'(sep_pulse), 0);
      chk("t6_color", int'(out_color), 0);
      chk("t6_err", int'(err_illegal), 0);
      chk("t6_stall_clr", int'(dut.stall_q), 0);
      chk("t6_state", int'(dut.state_q), int'(EMPTY));
      chk("t6_grant", int'(grant), 1);
      req = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step("t6_idle", 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, RED);

      chk("scoreboard_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/color_stream_arbiter.md
# color_stream_arbiter

Round-robin arbiter that lets N requesters share one 2-bit color stream, which feeds the downstream coloring checker. Grants are issued so that the emitted stream never contains three consecutive equal colors. A 2-bit history FSM tracks the last color and its run length. If every pending request is blocked by the run rule, the block inserts a separator symbol (2'b11) after a bounded stall; the separator resets both its own history and the checker's.

## Interface
- N, default 4: number of requesters, 2..8.
- STALL_MAX, default 4: consecutive blocked cycles before a separator is inserted, 1..15.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  request per requester; held high until granted.
- req_color  in  2N  color of requester i at bits [2i+1:2i]; 2'b11 is illegal.
- flush  in  1  clear history and stall count; no grant that cycle.
- grant  out  N  one-hot or zero, combinational, same cycle as req.
- out_valid  out  1  registered; out_color is meaningful this cycle.
- out_color  out  2  registered emitted symbol; 2'b11 means separator.
- sep_pulse  out  1  registered; high in the cycle a separator is emitted.
- err_illegal  out  1  sticky; set when a requesting input carries 2'b11.

## Operation
- History FSM states:
  - EMPTY: no history.
  - RUN1: last color C, run length 1.
  - RUN2: last color C, run length 2.
  - last_color is a 2-bit register.
- Eligibility of requester i: req[i]=1, its color != 2'b11, and NOT (state==RUN2 and color==last_color).
- Arbitration:
  - Search eligible requesters starting at rr_ptr, wrapping modulo N.
  - The first hit is granted.
  - After a grant to index k, rr_ptr <= (k+1) mod N. rr_ptr is unchanged when there is no grant.
- State transitions on a grant of color X:
  - EMPTY -> RUN1(X).
  - RUN1(C) -> RUN2(C) if X==C, else RUN1(X).
  - RUN2(C) -> RUN1(X); X!=C is guaranteed by eligibility.
- Idle cycles (no req, or none eligible) do not change history.
- Stall counter:
  - Increments when req is nonzero and no requester is eligible.
  - Clears on any grant, on flush, and when req==0.
  - Saturates at STALL_MAX.
- Separator insertion:
  - When the stall count == STALL_MAX at the start of a cycle, that cycle issues no grant.
  - Next cycle: out_valid=1, out_color=2'b11, sep_pulse=1.
  - History -> EMPTY and stall count -> 0.
- Requesters with illegal color 2'b11 are never granted. err_illegal is set and held until reset.
- flush has priority over everything:
  - grant = 0 that cycle.
  - State -> EMPTY, stall count -> 0, out_valid=0 next cycle.
  - rr_ptr is kept.

## Timing
- Reset values: out_valid=0, out_color=2'b00, sep_pulse=0, err_illegal=0, state EMPTY, last_color=2'b00, rr_ptr=0, stall count 0. grant then depends only on req (all eligible).
- Latency: grant in cycle t gives out_valid=1 with the granted color in cycle t+1. Single-cycle throughput: one grant per cycle.
- Requester handshake: the requester drops req (or presents its next color) in the cycle after its grant. Holding req high means a new request.
- Simultaneous flush and separator-due: flush wins; no separator is emitted.
- Reset mid-stream clears all registers immediately, including a pending separator.
- grant never asserts when flush=1 or on a separator-insertion cycle.

## Structure
- Shared package (coloring_pkg):
  - Color constants: RED=2'b00, GREEN=2'b01, BLUE=2'b10, SEP=2'b11.
  - History state encoding EMPTY/RUN1/RUN2.
  - The same constants serve the checker.
- Sub-module rr_pick, natural to factor out: N-bit eligibility mask plus rr_ptr in, one-hot grant plus index out, purely combinational.
- Top level holds the history FSM, rr_ptr, stall counter and output registers.

## Test plan
- Reset, then requester 0 alone sends RED for 3 cycles:
  - grants on cycles 1 and 2.
  - Cycle 3 blocked.
  - After STALL_MAX=4 blocked cycles, out_color=2'b11 with sep_pulse=1.
  - Next RED granted.
- All 4 requesters request GREEN, BLUE, RED, GREEN continuously:
  - grants rotate 0,1,2,3,0.
  - out_color follows one cycle later.
- History RUN2(BLUE), req0=BLUE, req1=RED, rr_ptr=0 -> grant=4'b0010, out_color=RED next cycle, state RUN1(RED).
- req2 with color 2'b11 and req3=GREEN -> grant=4'b1000, err_illegal=1 and stays 1.
- flush asserted in the same cycle as an eligible req0 -> grant=0, out_valid=0 next cycle, state EMPTY.
- rst_n dropped asynchronously while stalled at count 3 -> all outputs at reset values immediately, no separator afterwards.
